// File: rtl/melay_sequence_gen_if.sv
// Handshake/bus bundle for the serial pattern transmitter.
//   master : drives start/pattern/reps/gap, observes q/q_valid/busy/done
//   slave  : the transmitter itself
interface melay_sequence_gen_if #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) ();
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] reps;
    logic [GAP_W-1:0] gap;
    logic             q;
    logic             q_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, pattern, reps, gap,
        input  q, q_valid, busy, done
    );

    modport slave (
        input  start, pattern, reps, gap,
        output q, q_valid, busy, done
    );
endinterface

// File: rtl/melay_sequence_gen.sv
// Serial pattern transmitter. On an accepted start it shifts a PAT_W-bit
// pattern out MSB-first, reps times, with gap zero bits between copies.
// Ports:
//   clk        single clock, posedge
//   rst        synchronous, active-high reset
//   bus.start  request, accepted only when busy=0
//   bus.pattern/reps/gap  transfer parameters, sampled at accepted start
//   bus.q      serial data bit (registered)
//   bus.q_valid q carries a pattern or gap bit
//   bus.busy   transfer in progress
//   bus.done   one-cycle pulse after the final bit (or after a reps=0 start)
//
// state | meaning
// IDLE  | no transfer; q=0, q_valid=0
// SEND  | q shows a pattern bit
// GAP   | q shows an inter-copy zero bit
module melay_sequence_gen #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    melay_sequence_gen_if.slave bus
);
    localparam int BIT_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state;
    logic [PAT_W-1:0] shreg;     // bits still to be sent, left-aligned
    logic [PAT_W-1:0] pat_l;
    logic [CNT_W-1:0] reps_rem;  // copies remaining, including the one in flight
    logic [GAP_W-1:0] gap_l;
    logic [BIT_W-1:0] bit_cnt;   // bits of the current copy still to emit after q
    logic [GAP_W-1:0] gap_cnt;   // gap bits still to emit after q
    logic             q_r;
    logic             q_valid_r;
    logic             busy_r;
    logic             done_r;

    assign bus.q       = q_r;
    assign bus.q_valid = q_valid_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;

    // Outputs are computed one edge ahead, so each branch loads the values
    // that q/q_valid/busy/done must show in the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            pat_l     <= '0;
            reps_rem  <= '0;
            gap_l     <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            q_r       <= 1'b0;
            q_valid_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    q_r       <= 1'b0;
                    q_valid_r <= 1'b0;
                    busy_r    <= 1'b0;
                    if (bus.start) begin
                        if (bus.reps != '0) begin
                            state     <= SEND;
                            pat_l     <= bus.pattern;
                            reps_rem  <= bus.reps;
                            gap_l     <= bus.gap;
                            q_r       <= bus.pattern[PAT_W-1];
                            shreg     <= {bus.pattern[PAT_W-2:0], 1'b0};
                            bit_cnt   <= BIT_LAST;
                            q_valid_r <= 1'b1;
                            busy_r    <= 1'b1;
                        end else begin
                            done_r <= 1'b1;
                        end
                    end
                end

                SEND: begin
                    if (bit_cnt != '0) begin
                        q_r     <= shreg[PAT_W-1];
                        shreg   <= {shreg[PAT_W-2:0], 1'b0};
                        bit_cnt <= bit_cnt - 1'b1;
                    end else if (reps_rem > CNT_W'(1)) begin
                        reps_rem <= reps_rem - 1'b1;
                        if (gap_l != '0) begin
                            state   <= GAP;
                            q_r     <= 1'b0;
                            gap_cnt <= gap_l - 1'b1;
                        end else begin
                            // back-to-back copy: no idle bit between copies
                            q_r     <= pat_l[PAT_W-1];
                            shreg   <= {pat_l[PAT_W-2:0], 1'b0};
                            bit_cnt <= BIT_LAST;
                        end
                    end else begin
                        state     <= IDLE;
                        reps_rem  <= '0;
                        q_r       <= 1'b0;
                        q_valid_r <= 1'b0;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                    end
                end

                GAP: begin
                    if (gap_cnt != '0) begin
                        q_r     <= 1'b0;
                        gap_cnt <= gap_cnt - 1'b1;
                    end else begin
                        state   <= SEND;
                        q_r     <= pat_l[PAT_W-1];
                        shreg   <= {pat_l[PAT_W-2:0], 1'b0};
                        bit_cnt <= BIT_LAST;
                    end
                end

                default: begin
                    state     <= IDLE;
                    q_r       <= 1'b0;
                    q_valid_r <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_melay_sequence_gen.sv
module tb_melay_sequence_gen;
    localparam int PAT_W = 3;
    localparam int CNT_W = 8;
    localparam int GAP_W = 4;

    typedef struct {
        bit kind;      // 0: data bit, 1: done pulse
        bit val;
        int busy_len;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    melay_sequence_gen_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) sif ();

    melay_sequence_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    int   busy_cnt = 0;
    int   det_state = 0;
    int   det_hits = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // hand-computed stream, MSB of bits[n-1:0] first
    task automatic push_bits(input logic [31:0] bits, input int n);
        exp_t e;
        for (int i = n - 1; i >= 0; i--) begin
            e.kind = 1'b0;
            e.val = bits[i];
            e.busy_len = 0;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_done(input int busy_len);
        exp_t e;
        e.kind = 1'b1;
        e.val = 1'b0;
        e.busy_len = busy_len;
        exp_q.push_back(e);
    endtask

    // drive start for one cycle (call right after a posedge)
    task automatic pulse_start(input logic [PAT_W-1:0] p, input int r, input int g);
        sif.start   = 1'b1;
        sif.pattern = p;
        sif.reps    = CNT_W'(r);
        sif.gap     = GAP_W'(g);
        @(posedge clk); #1;
        sif.start   = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_drain_left"}, exp_q.size(), 0);
    endtask

    // monitor: pops expectation whenever the DUT presents a bit or a done
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (sif.q_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_bit", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("bit_kind", int'(e.kind), 0);
                    check("q_value", int'(sif.q), int'(e.val));
                end
            end
            if (sif.busy === 1'b1) busy_cnt++;
            if (sif.done === 1'b1) begin
                check("done_quiet", int'(sif.busy) + int'(sif.q_valid), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_kind", int'(e.kind), 1);
                    check("busy_cycles", busy_cnt, e.busy_len);
                end
                busy_cnt = 0;
            end
            if (rst) busy_cnt = 0;
            // non-overlapping 101 Mealy detector fed with the raw stream
            case (det_state)
                0: det_state = (sif.q === 1'b1) ? 1 : 0;
                1: det_state = (sif.q === 1'b1) ? 1 : 2;
                default: begin
                    if (sif.q === 1'b1) det_hits++;
                    det_state = 0;
                end
            endcase
        end
    end

    initial begin
        sif.start = 1'b0;
        sif.pattern = '0;
        sif.reps = '0;
        sif.gap = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_q", int'(sif.q), 0);
        check("rst_q_valid", int'(sif.q_valid), 0);
        check("rst_busy", int'(sif.busy), 0);
        check("rst_done", int'(sif.done), 0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // single copy
        push_bits(32'b101, 3); push_done(3);
        pulse_start(3'b101, 1, 0);
        check("t1_busy_c1", int'(sif.busy), 1);
        wait_drain("t1", 20);
        @(posedge clk); #1;
        check("t1_idle_after", int'(sif.q_valid) + int'(sif.busy) + int'(sif.done), 0);

        // three copies with 2-bit gaps, checked by the 101 detector too
        det_state = 0; det_hits = 0;
        push_bits(32'b1010010100101, 13); push_done(13);
        pulse_start(3'b101, 3, 2);
        wait_drain("t2", 40);
        check("t2_detector_hits", det_hits, 3);

        // two copies, no gap
        push_bits(32'b101101, 6); push_done(6);
        pulse_start(3'b101, 2, 0);
        wait_drain("t3", 30);

        // reps=0: lone done, no busy, no bits
        push_done(0);
        pulse_start(3'b111, 0, 3);
        check("t4_busy_c1", int'(sif.busy), 0);
        check("t4_done_c1", int'(sif.done), 1);
        @(posedge clk); #1;
        check("t4_done_c2", int'(sif.done), 0);
        wait_drain("t4", 5);

        // start ignored while busy, back-to-back start in the done cycle
        push_bits(32'b101, 3); push_done(3);
        push_bits(32'b110, 3); push_done(3);
        pulse_start(3'b101, 1, 0);            // now c1
        @(posedge clk); #1;                   // c2
        pulse_start(3'b111, 5, 1);            // ignored, now c3
        @(posedge clk); #1;                   // c4: done cycle
        check("t5_done_c4", int'(sif.done), 1);
        pulse_start(3'b110, 1, 0);            // accepted, c5 first bit
        check("t5_busy_c5", int'(sif.busy), 1);
        check("t5_q_c5", int'(sif.q), 1);
        wait_drain("t5", 20);

        // reset mid-transfer aborts without done, then a fresh start
        push_bits(32'b10, 2);
        pulse_start(3'b101, 3, 1);            // c1
        @(posedge clk); #1;                   // c2
        rst = 1'b1;
        sif.start = 1'b1;                     // reset wins over start
        sif.pattern = 3'b111; sif.reps = 8'd1;
        @(posedge clk); #1;                   // c3
        rst = 1'b0;
        sif.start = 1'b0;
        check("t6_q_c3", int'(sif.q), 0);
        check("t6_q_valid_c3", int'(sif.q_valid), 0);
        check("t6_busy_c3", int'(sif.busy), 0);
        check("t6_done_c3", int'(sif.done), 0);
        wait_drain("t6", 5);
        push_bits(32'b0110011, 7); push_done(7);
        @(posedge clk); #1;                   // c4
        pulse_start(3'b011, 2, 1);
        wait_drain("t6b", 30);

        // maximum gap
        push_bits(32'b100000000000000000100, 21); push_done(21);
        pulse_start(3'b100, 2, 15);
        wait_drain("t7", 40);

        repeat (3) @(posedge clk);
        #1;
        check("end_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
